// File: rtl/slu_pkg.sv
// Shared types for the sensitivity logic unit: reduction mode encoding and FSM states.
package slu_pkg;

    typedef enum logic [1:0] {
        MODE_AND  = 2'd0,
        MODE_OR   = 2'd1,
        MODE_XOR  = 2'd2,
        MODE_NAND = 2'd3
    } mode_e;

    typedef enum logic {
        PRIME = 1'b0,
        RUN   = 1'b1
    } state_e;

endpackage

// File: rtl/slu_reduce.sv
// Combinational bitwise fold of N W-bit operands; the mode selects AND, OR, XOR or NAND.
module slu_reduce
    import slu_pkg::*;
#(
    parameter int unsigned W = 8,
    parameter int unsigned N = 2
) (
    input  logic [N*W-1:0] in_data_i,
    input  logic [1:0]     mode_i,
    output logic [W-1:0]   y_o
);

    logic [W-1:0] and_r;
    logic [W-1:0] or_r;
    logic [W-1:0] xor_r;

    always_comb begin
        and_r = '1;
        or_r  = '0;
        xor_r = '0;
        for (int unsigned i = 0; i < N; i++) begin
            and_r = and_r & in_data_i[i*W +: W];
            or_r  = or_r  | in_data_i[i*W +: W];
            xor_r = xor_r ^ in_data_i[i*W +: W];
        end
    end

    always_comb begin
        y_o = '0;
        unique case (mode_e'(mode_i))
            MODE_AND:  y_o = and_r;
            MODE_OR:   y_o = or_r;
            MODE_XOR:  y_o = xor_r;
            MODE_NAND: y_o = ~and_r;
            default:   y_o = '0;
        endcase
    end

endmodule

// File: rtl/sens_logic_unit.sv
// Registered reduction that re-evaluates only on a sensitive operand change, a mode change,
// a forced request or the priming edge after reset; flags when the held result is stale.
module sens_logic_unit
    import slu_pkg::*;
#(
    parameter int unsigned W     = 8,
    parameter int unsigned N     = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N*W-1:0]   in_data_i,
    input  logic [N-1:0]     sens_mask_i,
    input  logic [1:0]       mode_i,
    input  logic             force_eval_i,
    output logic [W-1:0]     y_o,
    output logic             y_valid_o,
    output logic             stale_o,
    output logic [CNT_W-1:0] eval_cnt_o
);

    state_e           state_q;
    logic [N*W-1:0]   prev_data_q;
    logic [1:0]       prev_mode_q;
    logic [W-1:0]     y_q;
    logic             y_valid_q;
    logic             stale_q, stale_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]     delta;
    logic             trigger;
    logic [W-1:0]     red;

    slu_reduce #(
        .W (W),
        .N (N)
    ) u_reduce (
        .in_data_i (in_data_i),
        .mode_i    (mode_i),
        .y_o       (red)
    );

    always_comb begin
        delta = '0;
        for (int unsigned i = 0; i < N; i++) begin
            delta[i] = (in_data_i[i*W +: W] != prev_data_q[i*W +: W]);
        end
    end

    assign trigger = (state_q == PRIME) | force_eval_i | (mode_i != prev_mode_q) |
                     (|(delta & sens_mask_i));

    always_comb begin
        cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        // Sticky until the next evaluation, even if the operand reverts.
        stale_d = stale_q | (|(delta & ~sens_mask_i));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= PRIME;
            prev_data_q <= '0;
            prev_mode_q <= '0;
            y_q         <= '0;
            y_valid_q   <= 1'b0;
            stale_q     <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= RUN;
            prev_data_q <= in_data_i;
            prev_mode_q <= mode_i;
            if (trigger) begin
                y_q       <= red;
                y_valid_q <= 1'b1;
                stale_q   <= 1'b0;
                cnt_q     <= cnt_d;
            end else begin
                y_valid_q <= 1'b0;
                stale_q   <= stale_d;
            end
        end
    end

    assign y_o        = y_q;
    assign y_valid_o  = y_valid_q;
    assign stale_o    = stale_q;
    assign eval_cnt_o = cnt_q;

endmodule

// File: tb/tb_sens_logic_unit.sv
// Self-checking bench for sens_logic_unit (W=4, N=2) against a behavioural reference model.
module tb_sens_logic_unit;

    localparam int unsigned W     = 4;
    localparam int unsigned N     = 2;
    localparam int unsigned CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [W-1:0]     a_op = '0;
    logic [W-1:0]     b_op = '0;
    logic [N-1:0]     mask = '0;
    logic [1:0]       mode = '0;
    logic             force_eval = 1'b0;
    logic [W-1:0]     y;
    logic             yv;
    logic             st;
    logic [CNT_W-1:0] cnt;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [W-1:0] m_y;
    logic         m_v;
    logic         m_st;
    int unsigned  m_cnt;
    logic         m_primed;
    logic [W-1:0] m_prev[N];
    logic [1:0]   m_pmode;

    sens_logic_unit #(
        .W     (W),
        .N     (N),
        .CNT_W (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_data_i    ({b_op, a_op}),
        .sens_mask_i  (mask),
        .mode_i       (mode),
        .force_eval_i (force_eval),
        .y_o          (y),
        .y_valid_o    (yv),
        .stale_o      (st),
        .eval_cnt_o   (cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_reduce(logic [W-1:0] x0, logic [W-1:0] x1,
                                                logic [1:0] md);
        logic [W-1:0] ops[N];
        logic [W-1:0] acc;
        ops[0] = x0;
        ops[1] = x1;
        acc = ops[0];
        for (int i = 1; i < N; i++) begin
            if (md == 2'd1) acc = acc | ops[i];
            else if (md == 2'd2) acc = acc ^ ops[i];
            else acc = acc & ops[i];
        end
        if (md == 2'd3) acc = ~acc;
        return acc;
    endfunction

    function automatic logic [21:0] exp_vec();
        return {m_y, m_v, m_st, CNT_W'(m_cnt)};
    endfunction

    function automatic string fmt(logic [21:0] v);
        return $sformatf("y=%h valid=%b stale=%b cnt=%h", v[21:18], v[17], v[16], v[15:0]);
    endfunction

    task automatic model_reset();
        m_y = '0; m_v = 1'b0; m_st = 1'b0; m_cnt = 0; m_primed = 1'b0;
        m_pmode = '0;
        for (int i = 0; i < N; i++) m_prev[i] = '0;
    endtask

    // Advance one rising edge, applying the specification's rules to the model first.
    task automatic tick();
        logic [W-1:0] ops[N];
        logic trig;
        logic ins;
        ops[0] = a_op;
        ops[1] = b_op;
        trig = !m_primed || force_eval || (mode != m_pmode);
        ins = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (ops[i] != m_prev[i]) begin
                if (mask[i]) trig = 1'b1;
                else ins = 1'b1;
            end
        end
        if (trig) begin
            m_y = ref_reduce(a_op, b_op, mode);
            m_v = 1'b1;
            m_st = 1'b0;
            if (m_cnt < 65535) m_cnt++;
        end else begin
            m_v = 1'b0;
            m_st = m_st || ins;
        end
        for (int i = 0; i < N; i++) m_prev[i] = ops[i];
        m_pmode = mode;
        m_primed = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if ({y, yv, st, cnt} !== 22'd0) begin
            failures++;
            $display("FAIL reset_state: got %s expected all zero", fmt({y, yv, st, cnt}));
        end
        a_op = 4'hF; b_op = 4'h3; mask = 2'b11; mode = 2'd0;
        #2 rst_n = 1'b1;
        tick();
        checks++;
        if ({y, yv, st, cnt} !== {4'h3, 1'b1, 1'b0, 16'd1}) begin
            failures++;
            $display("FAIL prime_eval: got %s expected y=3 valid=1 stale=0 cnt=0001",
                     fmt({y, yv, st, cnt}));
        end
        tick();
        checks++;
        if ({y, yv, st, cnt} !== exp_vec() || yv !== 1'b0) begin
            failures++;
            $display("FAIL prime_pulse_width: got %s expected %s", fmt({y, yv, st, cnt}),
                     fmt(exp_vec()));
        end
    endtask

    task automatic test_sensitivity();
        mask = 2'b01;
        b_op = 4'h0;
        tick();
        checks++;
        if ({y, yv, st, cnt} !== {4'h3, 1'b0, 1'b1, 16'd1}) begin
            failures++;
            $display("FAIL insensitive_change: got %s expected y=3 valid=0 stale=1 cnt=0001",
                     fmt({y, yv, st, cnt}));
        end
        a_op = 4'hE;
        tick();
        checks++;
        if ({y, yv, st, cnt} !== {4'h0, 1'b1, 1'b0, 16'd2}) begin
            failures++;
            $display("FAIL sensitive_change: got %s expected y=0 valid=1 stale=0 cnt=0002",
                     fmt({y, yv, st, cnt}));
        end
        mask = 2'b10;
        tick();
        checks++;
        if ({y, yv, st, cnt} !== exp_vec() || yv !== 1'b0) begin
            failures++;
            $display("FAIL mask_only_change: got %s expected %s", fmt({y, yv, st, cnt}),
                     fmt(exp_vec()));
        end
    endtask

    task automatic test_modes();
        logic [1:0]   modes[4];
        logic [W-1:0] want[4];
        modes = '{2'd0, 2'd2, 2'd3, 2'd1};
        want  = '{4'h2, 4'hC, 4'hD, 4'hE};
        mask = 2'b11;
        a_op = 4'hA; b_op = 4'h6;
        for (int i = 0; i < 4; i++) begin
            mode = modes[i];
            tick();
            checks++;
            if (y !== want[i] || yv !== 1'b1 || {y, yv, st, cnt} !== exp_vec()) begin
                failures++;
                $display("FAIL mode_%0d: got %s expected y=%h valid=1 (%s)", modes[i],
                         fmt({y, yv, st, cnt}), want[i], fmt(exp_vec()));
            end
            tick();
            checks++;
            if (yv !== 1'b0 || y !== want[i]) begin
                failures++;
                $display("FAIL mode_%0d_hold: got %s expected y=%h valid=0", modes[i],
                         fmt({y, yv, st, cnt}), want[i]);
            end
        end
    endtask

    task automatic test_frozen_then_force();
        logic [CNT_W-1:0] cnt0;
        logic [W-1:0]     y0;
        mask = 2'b00;
        y0 = y;
        cnt0 = cnt;
        for (int i = 0; i < 5; i++) begin
            b_op = ~b_op;
            tick();
            checks++;
            if ({y, yv, st, cnt} !== {y0, 1'b0, 1'b1, cnt0}) begin
                failures++;
                $display("FAIL frozen_toggle_%0d: got %s expected y=%h valid=0 stale=1 cnt=%h",
                         i, fmt({y, yv, st, cnt}), y0, cnt0);
            end
        end
        force_eval = 1'b1;
        mode = 2'd0;
        tick();
        force_eval = 1'b0;
        checks++;
        if ({y, yv, st, cnt} !== {a_op & b_op, 1'b1, 1'b0, cnt0 + 16'd1}) begin
            failures++;
            $display("FAIL force_with_mode: got %s expected y=%h valid=1 stale=0 cnt=%h",
                     fmt({y, yv, st, cnt}), a_op & b_op, cnt0 + 16'd1);
        end
        tick();
        checks++;
        if ({y, yv, st, cnt} !== exp_vec() || cnt !== cnt0 + 16'd1) begin
            failures++;
            $display("FAIL force_single_count: got %s expected %s", fmt({y, yv, st, cnt}),
                     fmt(exp_vec()));
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) < 3) a_op = W'($urandom);
            if ($urandom_range(0, 9) < 3) b_op = W'($urandom);
            if ($urandom_range(0, 9) < 2) mask = N'($urandom);
            if ($urandom_range(0, 9) < 1) mode = 2'($urandom);
            force_eval = ($urandom_range(0, 9) == 0);
            tick();
            checks++;
            if ({y, yv, st, cnt} !== exp_vec()) begin
                failures++;
                $display("FAIL random_%0d: got %s expected %s", i, fmt({y, yv, st, cnt}),
                         fmt(exp_vec()));
            end
        end
        force_eval = 1'b0;
    endtask

    task automatic test_saturation();
        int bad = 0;
        force_eval = 1'b1;
        for (int i = 0; i < 65540; i++) begin
            a_op = W'($urandom);
            tick();
            checks++;
            if (yv !== 1'b1 || y !== m_y) begin
                failures++;
                bad++;
                if (bad < 5)
                    $display("FAIL sat_valid_%0d: got %s expected %s", i,
                             fmt({y, yv, st, cnt}), fmt(exp_vec()));
            end
        end
        checks++;
        if (cnt !== 16'hFFFF) begin
            failures++;
            $display("FAIL sat_count: got cnt=%h expected ffff", cnt);
        end
        tick();
        checks++;
        if (cnt !== 16'hFFFF || yv !== 1'b1) begin
            failures++;
            $display("FAIL sat_hold: got cnt=%h valid=%b expected ffff 1", cnt, yv);
        end
        force_eval = 1'b0;
    endtask

    task automatic test_async_reset();
        mask = 2'b01;
        for (int i = 0; i < 4; i++) begin
            b_op = W'($urandom);
            tick();
        end
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({y, yv, st, cnt} !== 22'd0) begin
            failures++;
            $display("FAIL async_reset: got %s expected all zero", fmt({y, yv, st, cnt}));
        end
        #2 rst_n = 1'b1;
        a_op = 4'h9; b_op = 4'h5; mode = 2'd2;
        tick();
        checks++;
        if ({y, yv, st, cnt} !== {4'hC, 1'b1, 1'b0, 16'd1} ||
            {y, yv, st, cnt} !== exp_vec()) begin
            failures++;
            $display("FAIL reprime: got %s expected y=c valid=1 stale=0 cnt=0001",
                     fmt({y, yv, st, cnt}));
        end
    endtask

    initial begin
        test_reset();
        test_sensitivity();
        test_modes();
        test_frozen_then_force();
        test_random();
        test_saturation();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
